dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory (dataMem) between the pipeline memory stage and a secondary debug/loader port.
- Sequences multi-cycle memory accesses and stalls the pipeline while the memory is busy or owned by the debug port.
- Sits between the memory-stage control/data signals and the dataMem instance.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles per memory transaction (legal 1..4); control/address/data held stable for all MEM_LAT cycles.
- STARVE_MAX, 4, consecutive denied debug-request cycles before debug gets priority (legal 1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p_memRead  in  1  pipeline load request
- p_memWrite  in  1  pipeline store request
- p_address  in  ADDR_W  pipeline address (alu_outM)
- p_wdata  in  DATA_W  pipeline store data
- p_rdata  out  DATA_W  pipeline load data, valid in the completing cycle
- p_stall  out  1  freeze IF..M, hold M inputs stable
- d_req  in  1  debug request
- d_we  in  1  debug write (1) / read (0)
- d_address  in  ADDR_W  debug address
- d_wdata  in  DATA_W  debug write data
- d_gnt  out  1  one-cycle accept pulse
- d_rvalid  out  1  one-cycle completion pulse (reads and writes)
- d_rdata  out  DATA_W  registered debug read data
- mem_memRead  out  1  to dataMem
- mem_memWrite  out  1  to dataMem
- mem_address  out  ADDR_W  to dataMem
- mem_dataWrite  out  DATA_W  to dataMem
- mem_dataRead  in  DATA_W  from dataMem (combinational read)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, starve=0, d_gnt=0, d_rvalid=0, d_rdata=0, mem_memRead=0, mem_memWrite=0, p_stall=0, p_rdata=0.
- Pipeline request is p_memRead|p_memWrite. If both are high, it is treated as a write.
- FSM states: IDLE, BUSY_P, BUSY_D.
- IDLE with debug priority (d_req && starve==STARVE_MAX, or d_req with no pipeline request):
  - Grant debug: d_gnt=1 this cycle; latch d_address/d_wdata/d_we.
  - Drive mem from debug inputs.
  - If a pipeline request is present, p_stall=1.
  - If MEM_LAT==1, complete this cycle; otherwise go to BUSY_D with cnt=MEM_LAT-1.
- IDLE, other cases with a pipeline request: grant pipeline.
  - Mem is driven combinationally from p_* inputs; the request is also latched.
  - If MEM_LAT==1: p_stall=0, p_rdata=mem_dataRead, zero overhead.
  - Otherwise: p_stall=1, go to BUSY_P with cnt=MEM_LAT-1.
- BUSY_x:
  - Drive mem from the latched request; decrement cnt.
  - Final cycle is cnt==1; then return to IDLE.
  - BUSY_P final cycle: p_stall=0, p_rdata=mem_dataRead.
  - BUSY_P non-final cycles: p_stall=1.
  - BUSY_D: p_stall=1 whenever a pipeline request is present.
- Debug completion: d_rdata captures mem_dataRead at the end of the final cycle; d_rvalid pulses the next cycle; d_rdata holds until the next debug read.
- Starvation counter:
  - Increments each cycle d_req=1 and d_gnt=0; saturates at STARVE_MAX.
  - Cleared on d_gnt or when d_req=0.
- No new grant while BUSY; back-to-back grants are allowed from IDLE in the cycle after a final cycle.
- Idle: mem_memRead=mem_memWrite=0; address and write data are don't-care but driven to 0.
- Reset mid-transaction aborts it: no d_rvalid, no write completion guaranteed, p_stall drops immediately.
- d_req deasserted after d_gnt has no effect on the accepted transaction.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined: adds outputs perf_stall_cycles[31:0] (counts cycles p_stall=1) and perf_d_grants[31:0] (counts d_gnt pulses). Both wrap at 2^32 and reset to 0.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg: FSM state encoding (IDLE=2'd0, BUSY_P=2'd1, BUSY_D=2'd2); default widths; MEM_LAT/STARVE_MAX legal limits.
- One natural sub-module: dmem_arb_starve_ctr, the saturating starvation counter exposing starve_hit.

Test Plan:
- MEM_LAT=1, pipeline lw from 0x10 holding 0xDEADBEEF, no debug → p_stall never 1; p_rdata=0xDEADBEEF same cycle.
- MEM_LAT=3, pipeline sw 0x55 to 0x20 → p_stall=1 for 2 cycles; mem_memWrite held 3 cycles; a later lw returns 0x55.
- Debug read of 0x20 while pipeline idle, MEM_LAT=2 → d_gnt at T0; d_rvalid at T2 with d_rdata=0x55.
- Continuous pipeline requests plus d_req, STARVE_MAX=4 → debug granted on the cycle starve reaches 4; pipeline stalled for that transaction; starve reset to 0.
- p_memRead and p_memWrite both high → write performed; no read data expected.
- Reset asserted in BUSY_D cycle 1 of 3 → next cycle IDLE, d_rvalid never pulses, p_stall=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM encoding, default widths and parameter limits for the data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_P = 2'd1, BUSY_D = 2'd2} state_t;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;
   localparam int STARVE_MIN = 1;
   localparam int STARVE_LIM = 15;
   localparam int CNT_W = 2;
   localparam int STARVE_W = 4;
   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating count of consecutive denied debug-request cycles.
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_req_i,
   input  logic d_gnt_i,
   output logic starve_hit_o
);
   logic [STARVE_W-1:0] starve_q;
   assign starve_hit_o = starve_q == STARVE_W'(STARVE_MAX);
   always_ff @(posedge clk_i) begin
      if (rst_i || !d_req_i || d_gnt_i) starve_q <= '0;
      else if (!starve_hit_o) starve_q <= starve_q + 1'b1;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline M stage and a debug/loader port.
// Define DMEM_ARB_PERF_EN to add stall-cycle and debug-grant performance counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              p_memRead,
   input  logic              p_memWrite,
   input  logic [ADDR_W-1:0] p_address,
   input  logic [DATA_W-1:0] p_wdata,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_memRead,
   output logic              mem_memWrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataWrite,
   input  logic [DATA_W-1:0] mem_dataRead
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_d_grants
`endif
);
   localparam int LAT = clamp(MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
   localparam int SMAX = clamp(STARVE_MAX, STARVE_MIN, STARVE_LIM);
   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              lat_we_q;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [DATA_W-1:0] lat_wdata_q;
   logic              d_rvalid_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              p_req, starve_hit, idle, dbg_pick, p_pick, last, p_done, d_done;
   assign p_req    = p_memRead | p_memWrite;
   assign idle     = state_q == IDLE;
   assign dbg_pick = idle && d_req && (starve_hit || !p_req);
   assign p_pick   = idle && p_req && !dbg_pick;
   assign last     = cnt_q == CNT_W'(1);
   assign p_done   = (p_pick && LAT == 1) || (state_q == BUSY_P && last);
   assign d_done   = (dbg_pick && LAT == 1) || (state_q == BUSY_D && last);
   // Every output is forced quiet during reset so an aborted access releases the pipeline at once.
   assign d_gnt         = !reset && dbg_pick;
   assign mem_memWrite  = !reset && (dbg_pick ? d_we : p_pick ? p_memWrite : !idle && lat_we_q);
   assign mem_memRead   = !reset && (dbg_pick ? !d_we : p_pick ? !p_memWrite : !idle && !lat_we_q);
   assign mem_address   = reset ? '0 : dbg_pick ? d_address : p_pick ? p_address : idle ? '0 : lat_addr_q;
   assign mem_dataWrite = reset ? '0 : dbg_pick ? d_wdata : p_pick ? p_wdata : idle ? '0 : lat_wdata_q;
   assign p_stall       = !reset && (dbg_pick ? p_req : p_pick ? LAT != 1 :
                                     state_q == BUSY_P ? !last : state_q == BUSY_D && p_req);
   assign p_rdata       = (!reset && p_done) ? mem_dataRead : '0;
   assign d_rvalid      = d_rvalid_q;
   assign d_rdata       = d_rdata_q;
   dmem_arb_starve_ctr #(.STARVE_MAX(SMAX)) u_starve (
      .clk_i        (clock),
      .rst_i        (reset),
      .d_req_i      (d_req),
      .d_gnt_i      (d_gnt),
      .starve_hit_o (starve_hit)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= '0;
      end else begin
         d_rvalid_q <= d_done;
         if (d_done && !(idle ? d_we : lat_we_q)) d_rdata_q <= mem_dataRead;
         if (dbg_pick || p_pick) begin
            lat_we_q    <= dbg_pick ? d_we : p_memWrite;
            lat_addr_q  <= dbg_pick ? d_address : p_address;
            lat_wdata_q <= dbg_pick ? d_wdata : p_wdata;
            if (LAT > 1) begin
               state_q <= dbg_pick ? BUSY_D : BUSY_P;
               cnt_q   <= CNT_W'(LAT - 1);
            end
         end else if (!idle) begin
            cnt_q <= cnt_q - 1'b1;
            if (last) state_q <= IDLE;
         end
      end
   end
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall_q, perf_gnt_q;
   assign perf_stall_cycles = perf_stall_q;
   assign perf_d_grants     = perf_gnt_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_q <= '0;
         perf_gnt_q   <= '0;
      end else begin
         perf_stall_q <= perf_stall_q + 32'(p_stall);
         perf_gnt_q   <= perf_gnt_q + 32'(d_gnt);
      end
   end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of three arbiter instances (MEM_LAT 1, 2, 3) each with its own memory model.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst    [3];
   logic        p_rd   [3];
   logic        p_wr   [3];
   logic [31:0] p_addr [3];
   logic [31:0] p_wd   [3];
   logic [31:0] p_rdat [3];
   logic        p_stl  [3];
   logic        d_req  [3];
   logic        d_we   [3];
   logic [31:0] d_addr [3];
   logic [31:0] d_wd   [3];
   logic        d_gnt  [3];
   logic        d_rv   [3];
   logic [31:0] d_rdat [3];
   logic        m_rd   [3];
   logic        m_wr   [3];
   logic [31:0] m_addr [3];
   logic [31:0] m_wd   [3];
   logic [31:0] m_dr   [3];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_inst
      logic [31:0] mem [64];
      assign m_dr[g] = mem[m_addr[g][7:2]];
      always @(posedge clk) if (m_wr[g]) mem[m_addr[g][7:2]] <= m_wd[g];
      dmem_arbiter #(.MEM_LAT(g + 1), .STARVE_MAX(4)) u_dut (
         .clock         (clk),
         .reset         (rst[g]),
         .p_memRead     (p_rd[g]),
         .p_memWrite    (p_wr[g]),
         .p_address     (p_addr[g]),
         .p_wdata       (p_wd[g]),
         .p_rdata       (p_rdat[g]),
         .p_stall       (p_stl[g]),
         .d_req         (d_req[g]),
         .d_we          (d_we[g]),
         .d_address     (d_addr[g]),
         .d_wdata       (d_wd[g]),
         .d_gnt         (d_gnt[g]),
         .d_rvalid      (d_rv[g]),
         .d_rdata       (d_rdat[g]),
         .mem_memRead   (m_rd[g]),
         .mem_memWrite  (m_wr[g]),
         .mem_address   (m_addr[g]),
         .mem_dataWrite (m_wd[g]),
         .mem_dataRead  (m_dr[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; p_rd[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wd[i] = '0;
      end
      tick; tick;
      // requests present while reset is held must not reach memory
      p_rd[0] = 1'b1; d_req[0] = 1'b1;
      smp;
      chk("rst_gnt", d_gnt[0], 0);
      chk("rst_mrd", m_rd[0], 0);
      chk("rst_stall", p_stl[0], 0);
      chk("rst_rvalid", d_rv[0], 0);
      chk("rst_drdata", d_rdat[0], 0);
      chk("rst_prdata", p_rdat[0], 0);
      tick;
      p_rd[0] = 1'b0; d_req[0] = 1'b0;
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      // LAT=1: store DEADBEEF to 0x10 then load it back with no stall
      p_wr[0] = 1'b1; p_addr[0] = 32'h10; p_wd[0] = 32'hDEADBEEF;
      smp;
      chk("l1_sw_stall", p_stl[0], 0);
      chk("l1_sw_mwr", m_wr[0], 1);
      tick;
      p_wr[0] = 1'b0; p_rd[0] = 1'b1;
      smp;
      chk("l1_lw_stall", p_stl[0], 0);
      chk("l1_lw_mrd", m_rd[0], 1);
      chk("l1_lw_rdata", p_rdat[0], 32'hDEADBEEF);
      tick;
      p_rd[0] = 1'b0;
      smp;
      chk("l1_idle_mrd", m_rd[0], 0);
      chk("l1_idle_addr", m_addr[0], 0);
      // LAT=3: store 0x55 to 0x20, two stall cycles, write held three cycles
      tick;
      p_wr[2] = 1'b1; p_addr[2] = 32'h20; p_wd[2] = 32'h55;
      smp;
      chk("l3_sw_t0_stall", p_stl[2], 1);
      chk("l3_sw_t0_mwr", m_wr[2], 1);
      chk("l3_sw_t0_addr", m_addr[2], 32'h20);
      tick; smp;
      chk("l3_sw_t1_stall", p_stl[2], 1);
      chk("l3_sw_t1_mwr", m_wr[2], 1);
      tick; smp;
      chk("l3_sw_t2_stall", p_stl[2], 0);
      chk("l3_sw_t2_mwr", m_wr[2], 1);
      chk("l3_sw_t2_wd", m_wd[2], 32'h55);
      tick;
      p_wr[2] = 1'b0;
      smp;
      chk("l3_sw_t3_mwr", m_wr[2], 0);
      chk("l3_sw_t3_stall", p_stl[2], 0);
      tick;
      p_rd[2] = 1'b1;
      smp;
      chk("l3_lw_t0_stall", p_stl[2], 1);
      tick; smp;
      chk("l3_lw_t1_stall", p_stl[2], 1);
      tick; smp;
      chk("l3_lw_t2_stall", p_stl[2], 0);
      chk("l3_lw_t2_rdata", p_rdat[2], 32'h55);
      tick;
      p_rd[2] = 1'b0;
      // LAT=2: debug write 0x55 to 0x20, d_req dropped right after the grant
      d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h20; d_wd[1] = 32'h55;
      smp;
      chk("l2_dw_t0_gnt", d_gnt[1], 1);
      chk("l2_dw_t0_mwr", m_wr[1], 1);
      tick;
      d_req[1] = 1'b0; d_addr[1] = 32'h0; d_wd[1] = 32'h0;
      smp;
      chk("l2_dw_t1_gnt", d_gnt[1], 0);
      chk("l2_dw_t1_mwr", m_wr[1], 1);
      chk("l2_dw_t1_addr", m_addr[1], 32'h20);
      chk("l2_dw_t1_rv", d_rv[1], 0);
      tick; smp;
      chk("l2_dw_t2_rv", d_rv[1], 1);
      chk("l2_dw_t2_mwr", m_wr[1], 0);
      // LAT=2: debug read of 0x20
      tick;
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h20;
      smp;
      chk("l2_dr_t0_gnt", d_gnt[1], 1);
      chk("l2_dr_t0_mrd", m_rd[1], 1);
      tick;
      d_req[1] = 1'b0;
      smp;
      chk("l2_dr_t1_gnt", d_gnt[1], 0);
      chk("l2_dr_t1_rv", d_rv[1], 0);
      tick; smp;
      chk("l2_dr_t2_rv", d_rv[1], 1);
      chk("l2_dr_t2_rdata", d_rdat[1], 32'h55);
      tick; smp;
      chk("l2_dr_t3_rv", d_rv[1], 0);
      chk("l2_dr_t3_rdata", d_rdat[1], 32'h55);
      // LAT=1 starvation: pipeline wins four cycles, debug wins the fifth
      tick;
      p_rd[0] = 1'b1; p_addr[0] = 32'h10;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
      for (int i = 0; i < 4; i++) begin
         smp;
         chk($sformatf("st_c%0d_gnt", i), d_gnt[0], 0);
         chk($sformatf("st_c%0d_stall", i), p_stl[0], 0);
         tick;
      end
      smp;
      chk("st_c4_gnt", d_gnt[0], 1);
      chk("st_c4_stall", p_stl[0], 1);
      tick; smp;
      chk("st_c5_gnt", d_gnt[0], 0);
      chk("st_c5_stall", p_stl[0], 0);
      chk("st_c5_rv", d_rv[0], 1);
      chk("st_c5_rdata", d_rdat[0], 32'hDEADBEEF);
      chk("st_c5_prdata", p_rdat[0], 32'hDEADBEEF);
      tick; smp;
      chk("st_c6_gnt", d_gnt[0], 0);
      tick;
      p_rd[0] = 1'b0; d_req[0] = 1'b0;
      // LAT=1: read and write both high is a write
      p_rd[0] = 1'b1; p_wr[0] = 1'b1; p_addr[0] = 32'h24; p_wd[0] = 32'hA5A5;
      smp;
      chk("rw_mwr", m_wr[0], 1);
      chk("rw_mrd", m_rd[0], 0);
      tick;
      p_wr[0] = 1'b0;
      smp;
      chk("rw_readback", p_rdat[0], 32'hA5A5);
      tick;
      p_rd[0] = 1'b0;
      // LAT=3: reset during the first BUSY_D cycle aborts the debug read
      d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h20;
      smp;
      chk("ab_t0_gnt", d_gnt[2], 1);
      tick;
      d_req[2] = 1'b0; p_rd[2] = 1'b1; p_addr[2] = 32'h20;
      smp;
      chk("ab_t1_stall", p_stl[2], 1);
      rst[2] = 1'b1;
      #1;
      chk("ab_t1_rst_stall", p_stl[2], 0);
      chk("ab_t1_rst_mrd", m_rd[2], 0);
      tick;
      rst[2] = 1'b0; p_rd[2] = 1'b0;
      smp;
      chk("ab_t2_stall", p_stl[2], 0);
      chk("ab_t2_mrd", m_rd[2], 0);
      chk("ab_t2_rv", d_rv[2], 0);
      tick; smp;
      chk("ab_t3_rv", d_rv[2], 0);
      tick; smp;
      chk("ab_t4_rv", d_rv[2], 0);
      chk("ab_t4_rdata", d_rdat[2], 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
